// File: rtl/pipeline_if.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake to a
// variable-latency instruction memory, and drives the IF/ID pipeline register.
module pipeline_if #(
    parameter logic [31:0] RESET_PC   = 32'h8000_0000,
    parameter logic [31:0] ILLOP_ADDR = 32'h8000_0004,
    parameter logic [31:0] XADR_ADDR  = 32'h8000_0008
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  PCSrc,
    input  logic        ALUout0,
    input  logic [31:0] ConBA,
    input  logic [25:0] JT,
    input  logic [31:0] PCin,
    input  logic        IF_Stall,
    input  logic        IF_Flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_PC,
    output logic [31:0] ID_PC,
    output logic [31:0] ID_instruction
);

    typedef enum logic [1:0] {
        REQ     = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_e;

    state_e      state_q,      state_d;
    logic [31:0] pc_q,         pc_d;
    logic [31:0] fetch_addr_q, fetch_addr_d;
    logic [31:0] hold_buf_q,   hold_buf_d;
    logic [31:0] pend_pc_q,    pend_pc_d;
    logic [31:0] id_pc_q,      id_pc_d;
    logic [31:0] id_instr_q,   id_instr_d;

    logic [31:0] pc4;
    logic        redirect;
    logic [31:0] target;

    // Supervisor bit survives the increment; carry out of bit 30 is dropped.
    assign pc4 = {pc_q[31], pc_q[30:0] + 31'd4};

    // NOTE: every output of a combinational block gets a default first so no
    // path through the case statement can infer a latch.
    always_comb begin
        redirect = 1'b0;
        target   = pc4;
        case (PCSrc)
            3'd1: begin
                redirect = !ALUout0;
                target   = ConBA;
            end
            3'd2: begin
                redirect = 1'b1;
                target   = {id_pc_q[31:28], JT, 2'b00};
            end
            3'd3: begin
                redirect = 1'b1;
                target   = PCin;
            end
            3'd4: begin
                redirect = 1'b1;
                target   = ILLOP_ADDR;
            end
            3'd5: begin
                redirect = 1'b1;
                target   = XADR_ADDR;
            end
            default: begin
                redirect = 1'b0;
                target   = pc4;
            end
        endcase
        if (IF_Stall) begin
            redirect = 1'b0;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fetch_addr_d = fetch_addr_q;
        hold_buf_d   = hold_buf_q;
        pend_pc_d    = pend_pc_q;
        id_pc_d      = id_pc_q;
        id_instr_d   = id_instr_q;

        case (state_q)
            REQ: begin
                if (imem_ack) begin
                    if (redirect) begin
                        pc_d         = target;
                        fetch_addr_d = target;
                        id_instr_d   = 32'h0;
                    end else if (IF_Stall) begin
                        hold_buf_d = imem_rdata;
                        state_d    = HOLD;
                    end else begin
                        id_instr_d   = imem_rdata;
                        id_pc_d      = pc4;
                        pc_d         = pc4;
                        fetch_addr_d = pc4;
                    end
                end else if (redirect) begin
                    // The outstanding request cannot be withdrawn; wait it out.
                    pend_pc_d  = target;
                    state_d    = DISCARD;
                    id_instr_d = 32'h0;
                end else if (!IF_Stall) begin
                    id_instr_d = 32'h0;
                end
            end

            HOLD: begin
                if (!IF_Stall) begin
                    state_d = REQ;
                    if (redirect) begin
                        pc_d         = target;
                        fetch_addr_d = target;
                        id_instr_d   = 32'h0;
                    end else begin
                        id_instr_d   = hold_buf_q;
                        id_pc_d      = pc4;
                        pc_d         = pc4;
                        fetch_addr_d = pc4;
                    end
                end
            end

            DISCARD: begin
                if (!IF_Stall) begin
                    id_instr_d = 32'h0;
                end
                if (redirect) begin
                    pend_pc_d = target;
                end
                if (imem_ack) begin
                    pc_d         = redirect ? target : pend_pc_q;
                    fetch_addr_d = redirect ? target : pend_pc_q;
                    state_d      = REQ;
                end
            end

            default: begin
                state_d = REQ;
            end
        endcase

        // Flush only overrides the IF/ID contents; PC and FSM proceed as above.
        if (IF_Flush) begin
            id_instr_d = 32'h0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= REQ;
            pc_q         <= RESET_PC;
            fetch_addr_q <= RESET_PC;
            hold_buf_q   <= 32'h0;
            pend_pc_q    <= 32'h0;
            id_pc_q      <= 32'h0;
            id_instr_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetch_addr_q <= fetch_addr_d;
            hold_buf_q   <= hold_buf_d;
            pend_pc_q    <= pend_pc_d;
            id_pc_q      <= id_pc_d;
            id_instr_q   <= id_instr_d;
        end
    end

    assign imem_req       = !reset && (state_q != HOLD);
    assign imem_addr      = fetch_addr_q;
    assign IF_PC          = pc_q;
    assign ID_PC          = id_pc_q;
    assign ID_instruction = id_instr_q;

endmodule

// File: tb/tb_pipeline_if.sv
// Directed testbench for pipeline_if; memory model returns ~address unless a
// fixed instruction word is forced.
module tb_pipeline_if;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  PCSrc;
    logic        ALUout0;
    logic [31:0] ConBA;
    logic [25:0] JT;
    logic [31:0] PCin;
    logic        IF_Stall;
    logic        IF_Flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] IF_PC;
    logic [31:0] ID_PC;
    logic [31:0] ID_instruction;

    logic        use_fixed;
    logic [31:0] fixed_rdata;

    int tests_run    = 0;
    int tests_failed = 0;

    assign imem_rdata = use_fixed ? fixed_rdata : ~imem_addr;

    always #5 clk = ~clk;

    pipeline_if dut (
        .clk            (clk),
        .reset          (reset),
        .PCSrc          (PCSrc),
        .ALUout0        (ALUout0),
        .ConBA          (ConBA),
        .JT             (JT),
        .PCin           (PCin),
        .IF_Stall       (IF_Stall),
        .IF_Flush       (IF_Flush),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .IF_PC          (IF_PC),
        .ID_PC          (ID_PC),
        .ID_instruction (ID_instruction)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; PCSrc = 3'd0; ALUout0 = 1'b1; ConBA = 32'h0; JT = 26'h0; PCin = 32'h0;
        IF_Stall = 1'b0; IF_Flush = 1'b0; imem_ack = 1'b1; use_fixed = 1'b0; fixed_rdata = 32'h0;
        step();
        step();
        tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req: got %b want 0", imem_req); end
        tests_run++; if (IF_PC !== 32'h80000000) begin tests_failed++; $display("FAIL reset_pc: got %h want 80000000", IF_PC); end
        tests_run++; if (ID_PC !== 32'h0) begin tests_failed++; $display("FAIL reset_id_pc: got %h want 00000000", ID_PC); end
        tests_run++; if (ID_instruction !== 32'h0) begin tests_failed++; $display("FAIL reset_id_instr: got %h want 00000000", ID_instruction); end
        reset = 1'b0;
        #1;
        tests_run++; if (imem_req !== 1'b1) begin tests_failed++; $display("FAIL post_reset_req: got %b want 1", imem_req); end
        tests_run++; if (imem_addr !== 32'h80000000) begin tests_failed++; $display("FAIL post_reset_addr: got %h want 80000000", imem_addr); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_addr [4];
        logic [31:0] exp_idpc [4];
        logic [31:0] exp_inst [4];
        exp_addr = '{32'h80000000, 32'h80000004, 32'h80000008, 32'h8000000C};
        exp_idpc = '{32'h80000004, 32'h80000008, 32'h8000000C, 32'h80000010};
        exp_inst = '{32'h7FFFFFFF, 32'h7FFFFFFB, 32'h7FFFFFF7, 32'h7FFFFFF3};
        imem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests_run++; if (imem_addr !== exp_addr[i]) begin tests_failed++; $display("FAIL seq_addr[%0d]: got %h want %h", i, imem_addr, exp_addr[i]); end
            step();
            tests_run++; if (ID_PC !== exp_idpc[i]) begin tests_failed++; $display("FAIL seq_id_pc[%0d]: got %h want %h", i, ID_PC, exp_idpc[i]); end
            tests_run++; if (ID_instruction !== exp_inst[i]) begin tests_failed++; $display("FAIL seq_instr[%0d]: got %h want %h", i, ID_instruction, exp_inst[i]); end
        end
    endtask

    task automatic test_delayed_ack();
        imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tests_run++; if (imem_addr !== 32'h80000010) begin tests_failed++; $display("FAIL delay_addr[%0d]: got %h want 80000010", i, imem_addr); end
            step();
            tests_run++; if (ID_instruction !== 32'h0) begin tests_failed++; $display("FAIL delay_bubble[%0d]: got %h want 00000000", i, ID_instruction); end
        end
        imem_ack = 1'b1;
        tests_run++; if (imem_addr !== 32'h80000010) begin tests_failed++; $display("FAIL delay_addr[3]: got %h want 80000010", imem_addr); end
        step();
        tests_run++; if (ID_instruction !== 32'h7FFFFFEF) begin tests_failed++; $display("FAIL delay_instr: got %h want 7fffffef", ID_instruction); end
        tests_run++; if (ID_PC !== 32'h80000014) begin tests_failed++; $display("FAIL delay_id_pc: got %h want 80000014", ID_PC); end
    endtask

    task automatic test_branch();
        imem_ack = 1'b1; PCSrc = 3'd1; ALUout0 = 1'b0; ConBA = 32'h00400100;
        step();
        tests_run++; if (ID_instruction !== 32'h0) begin tests_failed++; $display("FAIL br_taken_nop: got %h want 00000000", ID_instruction); end
        tests_run++; if (imem_addr !== 32'h00400100) begin tests_failed++; $display("FAIL br_taken_addr: got %h want 00400100", imem_addr); end
        PCSrc = 3'd0;
        step();
        tests_run++; if (ID_instruction !== 32'hFFBFFEFF) begin tests_failed++; $display("FAIL br_target_instr: got %h want ffbffeff", ID_instruction); end
        PCSrc = 3'd1; ALUout0 = 1'b1;
        step();
        tests_run++; if (ID_PC !== 32'h00400108) begin tests_failed++; $display("FAIL br_not_taken_id_pc: got %h want 00400108", ID_PC); end
        tests_run++; if (ID_instruction !== 32'hFFBFFEFB) begin tests_failed++; $display("FAIL br_not_taken_instr: got %h want ffbffefb", ID_instruction); end
        PCSrc = 3'd7;
        step();
        tests_run++; if (ID_PC !== 32'h0040010C) begin tests_failed++; $display("FAIL pcsrc7_id_pc: got %h want 0040010c", ID_PC); end
        tests_run++; if (ID_instruction !== 32'hFFBFFEF7) begin tests_failed++; $display("FAIL pcsrc7_instr: got %h want ffbffef7", ID_instruction); end
        PCSrc = 3'd1; ALUout0 = 1'b0; ConBA = 32'h00400040;
        step();
        PCSrc = 3'd0; ALUout0 = 1'b1;
        tests_run++; if (IF_PC !== 32'h00400040) begin tests_failed++; $display("FAIL br_setup_pc: got %h want 00400040", IF_PC); end
    endtask

    task automatic test_redirect_inflight();
        imem_ack = 1'b0; PCSrc = 3'd3; PCin = 32'h00400200;
        step();
        PCSrc = 3'd0;
        tests_run++; if (ID_instruction !== 32'h0) begin tests_failed++; $display("FAIL jr_nop0: got %h want 00000000", ID_instruction); end
        tests_run++; if (imem_addr !== 32'h00400040 || imem_req !== 1'b1) begin tests_failed++; $display("FAIL jr_hold_addr0: got %h/%b want 00400040/1", imem_addr, imem_req); end
        step();
        tests_run++; if (imem_addr !== 32'h00400040) begin tests_failed++; $display("FAIL jr_hold_addr1: got %h want 00400040", imem_addr); end
        imem_ack = 1'b1;
        step();
        tests_run++; if (ID_instruction !== 32'h0) begin tests_failed++; $display("FAIL jr_stale_dropped: got %h want 00000000", ID_instruction); end
        tests_run++; if (imem_addr !== 32'h00400200) begin tests_failed++; $display("FAIL jr_new_addr: got %h want 00400200", imem_addr); end
        step();
        tests_run++; if (ID_instruction !== 32'hFFBFFDFF) begin tests_failed++; $display("FAIL jr_target_instr: got %h want ffbffdff", ID_instruction); end
        tests_run++; if (ID_PC !== 32'h00400204) begin tests_failed++; $display("FAIL jr_target_id_pc: got %h want 00400204", ID_PC); end
    endtask

    task automatic test_stall_hold();
        IF_Stall = 1'b1; imem_ack = 1'b1; use_fixed = 1'b1; fixed_rdata = 32'h24020005;
        step();
        use_fixed = 1'b0; imem_ack = 1'b0;
        tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL stall_req0: got %b want 0", imem_req); end
        tests_run++; if (ID_instruction !== 32'hFFBFFDFF) begin tests_failed++; $display("FAIL stall_id_held: got %h want ffbffdff", ID_instruction); end
        tests_run++; if (IF_PC !== 32'h00400204) begin tests_failed++; $display("FAIL stall_pc_held: got %h want 00400204", IF_PC); end
        step();
        tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL stall_req1: got %b want 0", imem_req); end
        tests_run++; if (ID_PC !== 32'h00400204) begin tests_failed++; $display("FAIL stall_id_pc_held: got %h want 00400204", ID_PC); end
        IF_Stall = 1'b0;
        step();
        tests_run++; if (ID_instruction !== 32'h24020005) begin tests_failed++; $display("FAIL hold_release_instr: got %h want 24020005", ID_instruction); end
        tests_run++; if (ID_PC !== 32'h00400208) begin tests_failed++; $display("FAIL hold_release_id_pc: got %h want 00400208", ID_PC); end
        tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h00400208) begin tests_failed++; $display("FAIL hold_release_req: got %b/%h want 1/00400208", imem_req, imem_addr); end
    endtask

    task automatic test_jump_flush_irq();
        imem_ack = 1'b1; PCSrc = 3'd1; ALUout0 = 1'b0; ConBA = 32'h8000003C;
        step();
        PCSrc = 3'd0; ALUout0 = 1'b1;
        step();
        tests_run++; if (ID_PC !== 32'h80000040) begin tests_failed++; $display("FAIL j_setup_id_pc: got %h want 80000040", ID_PC); end
        PCSrc = 3'd2; JT = 26'h0000010;
        step();
        PCSrc = 3'd0;
        tests_run++; if (IF_PC !== 32'h80000040) begin tests_failed++; $display("FAIL j_target: got %h want 80000040", IF_PC); end
        tests_run++; if (ID_instruction !== 32'h0) begin tests_failed++; $display("FAIL j_nop: got %h want 00000000", ID_instruction); end
        step();
        IF_Stall = 1'b1; IF_Flush = 1'b1;
        step();
        tests_run++; if (ID_instruction !== 32'h0) begin tests_failed++; $display("FAIL flush_over_stall: got %h want 00000000", ID_instruction); end
        tests_run++; if (IF_PC !== 32'h80000044) begin tests_failed++; $display("FAIL flush_stall_pc: got %h want 80000044", IF_PC); end
        IF_Stall = 1'b0; IF_Flush = 1'b0;
        step();
        tests_run++; if (ID_instruction !== 32'h7FFFFFBB) begin tests_failed++; $display("FAIL flush_hold_release: got %h want 7fffffbb", ID_instruction); end
        IF_Flush = 1'b1;
        step();
        IF_Flush = 1'b0;
        tests_run++; if (ID_instruction !== 32'h0) begin tests_failed++; $display("FAIL flush_fetch_nop: got %h want 00000000", ID_instruction); end
        tests_run++; if (IF_PC !== 32'h8000004C) begin tests_failed++; $display("FAIL flush_fetch_pc: got %h want 8000004c", IF_PC); end
        PCSrc = 3'd4;
        step();
        tests_run++; if (IF_PC !== 32'h80000004) begin tests_failed++; $display("FAIL illop_target: got %h want 80000004", IF_PC); end
        tests_run++; if (ID_instruction !== 32'h0) begin tests_failed++; $display("FAIL illop_nop: got %h want 00000000", ID_instruction); end
        PCSrc = 3'd5; imem_ack = 1'b0;
        step();
        PCSrc = 3'd0; imem_ack = 1'b1;
        tests_run++; if (imem_addr !== 32'h80000004) begin tests_failed++; $display("FAIL xadr_old_addr: got %h want 80000004", imem_addr); end
        step();
        tests_run++; if (IF_PC !== 32'h80000008 || ID_instruction !== 32'h0) begin tests_failed++; $display("FAIL xadr_target: got %h/%h want 80000008/00000000", IF_PC, ID_instruction); end
        step();
        tests_run++; if (ID_instruction !== 32'h7FFFFFF7) begin tests_failed++; $display("FAIL xadr_instr: got %h want 7ffffff7", ID_instruction); end
    endtask

    task automatic test_pc_wrap();
        imem_ack = 1'b1; PCSrc = 3'd1; ALUout0 = 1'b0; ConBA = 32'hFFFFFFFC;
        step();
        PCSrc = 3'd0; ALUout0 = 1'b1;
        step();
        tests_run++; if (ID_PC !== 32'h80000000) begin tests_failed++; $display("FAIL wrap_id_pc: got %h want 80000000", ID_PC); end
        tests_run++; if (IF_PC !== 32'h80000000) begin tests_failed++; $display("FAIL wrap_pc: got %h want 80000000", IF_PC); end
        tests_run++; if (ID_instruction !== 32'h00000003) begin tests_failed++; $display("FAIL wrap_instr: got %h want 00000003", ID_instruction); end
    endtask

    task automatic test_reset_midfetch();
        imem_ack = 1'b0;
        step();
        reset = 1'b1; imem_ack = 1'b1;
        #1;
        tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL midreset_req: got %b want 0", imem_req); end
        step();
        tests_run++; if (IF_PC !== 32'h80000000 || ID_PC !== 32'h0 || ID_instruction !== 32'h0) begin tests_failed++; $display("FAIL midreset_state: got %h/%h/%h want 80000000/00000000/00000000", IF_PC, ID_PC, ID_instruction); end
        reset = 1'b0;
        #1;
        tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h80000000) begin tests_failed++; $display("FAIL midreset_req_after: got %b/%h want 1/80000000", imem_req, imem_addr); end
        step();
        tests_run++; if (ID_PC !== 32'h80000004) begin tests_failed++; $display("FAIL midreset_first_fetch: got %h want 80000004", ID_PC); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_delayed_ack();
        test_branch();
        test_redirect_inflight();
        test_stall_hold();
        test_jump_flush_irq();
        test_pc_wrap();
        test_reset_midfetch();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
